fan_pwm_decoder: RTL

- Receive-side counterpart of the fan PWM generator: samples a single-wire PWM stream and recovers the 8-bit duty-cycle (speed) word that produced it.
- Measures high time and period rise-to-rise, checks the period against the expected frame length, and detects stuck-low / stuck-high lines.
- Sits on the fan feedback path, or on a loopback in the smart-house controller, so the controller can confirm the commanded fan speed.

---
 rtl/fan_pwm_decoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fan_pwm_decoder.sv
// fan_pwm_decoder: recovers the 8-bit duty word from a single-wire PWM stream.
// The line is synchronised, then high time and rise-to-rise period are measured.
// Each complete frame publishes its duty, a period check and a lock flag.
// A line that stays constant for TIMEOUT cycles is reported as stuck, with
// speed_out showing the level it is stuck at.
//
// Output handshake: speed_valid is a one-cycle strobe with no back-pressure.
// speed_out, period_err, locked and stuck are valid in the strobe cycle and
// hold their values until the next strobe.
module fan_pwm_decoder #(
    parameter int PERIOD      = 256,
    parameter int TOL         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2 * PERIOD
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       pwm_in,
    output logic [7:0] speed_out,
    output logic       speed_valid,
    output logic       period_err,
    output logic       locked,
    output logic       stuck
);

    // Counters are one bit wider than TIMEOUT needs, so they can saturate
    // above the timeout value and never wrap.
    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);
    localparam logic [CW-1:0] HI_LIM   = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] LO_LIM   = (PERIOD > TOL) ? CW'(PERIOD - TOL) : '0;
    localparam logic [CW-1:0] SPD_MAX  = CW'(255);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_d_q, pwm_d_d;
    logic                   pwm_s, rise, fall;

    state_t                 state_q, state_d;
    logic [CW-1:0]          per_cnt_q, per_cnt_d;
    logic [CW-1:0]          high_cnt_q, high_cnt_d;
    logic [CW-1:0]          per_inc, high_inc;
    logic                   meas_err;

    logic [7:0]             speed_q, speed_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   locked_q, locked_d;
    logic                   stuck_q, stuck_d;

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d_q;
    assign fall  = ~pwm_s & pwm_d_q;

    // Saturating increments: a counter parked at all-ones stays there.
    assign per_inc  = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
    assign high_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;

    // Period is judged on the count accumulated up to the cycle before the rise.
    assign meas_err = (per_cnt_q > HI_LIM) || (per_cnt_q < LO_LIM);

    // Shift the raw line through the synchroniser and keep a one-cycle delayed copy for edge detection.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_d_d = pwm_s;
    end

    // Measurement state machine: counts, edge handling, publication and timeout.
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_inc;
        high_cnt_d = high_cnt_q;
        speed_d    = speed_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        locked_d   = locked_q;
        stuck_d    = stuck_q;

        if (rise) begin
            // A rise always beats a coincident timeout. Only a rise that closes
            // a full HIGH+LOW frame publishes; the first rise after HUNT does not.
            if (state_q == LOW) begin
                speed_d  = (high_cnt_q > SPD_MAX) ? 8'hFF : high_cnt_q[7:0];
                perr_d   = meas_err;
                locked_d = ~meas_err;
                stuck_d  = 1'b0;
                valid_d  = 1'b1;
            end
            per_cnt_d  = CNT_ONE;
            high_cnt_d = CNT_ONE;
            state_d    = HIGH;
        end else if (per_cnt_q == TO_LIM) begin
            // Line has been constant too long: report its level and start hunting again.
            speed_d   = pwm_s ? 8'hFF : 8'h00;
            stuck_d   = 1'b1;
            locked_d  = 1'b0;
            perr_d    = 1'b0;
            valid_d   = 1'b1;
            per_cnt_d = CNT_ONE;
            state_d   = HUNT;
        end else begin
            case (state_q)
                HIGH: begin
                    if (pwm_s) begin
                        high_cnt_d = high_inc;
                    end
                    if (fall) begin
                        state_d = LOW;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All state and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (arst) begin
            sync_q     <= '0;
            pwm_d_q    <= 1'b0;
            state_q    <= HUNT;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            speed_q    <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            locked_q   <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            pwm_d_q    <= pwm_d_d;
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            speed_q    <= speed_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            locked_q   <= locked_d;
            stuck_q    <= stuck_d;
        end
    end

    assign speed_out   = speed_q;
    assign speed_valid = valid_q;
    assign period_err  = perr_q;
    assign locked      = locked_q;
    assign stuck       = stuck_q;

endmodule
